// File: rtl/ulpi_link.sv
// ulpi_link: link side of a ULPI PHY interface.
// The block turns register accesses and USB transmit packets into ULPI bus
// sequences (command byte, payload, stp). It also splits bytes driven by the
// PHY into RX CMD bytes (nxt low) and USB receive data bytes (nxt high).
// Every output except the tx_ready handshake comes straight from a flop.
module ulpi_link (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  inout  wire  [7:0] ulpi_data,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic [7:0] reg_rdata,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_cmd_valid,
  output logic [7:0] rx_cmd
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    REG_CMD     = 4'd1,
    REG_WDATA   = 4'd2,
    REG_STP     = 4'd3,
    REG_RD_TURN = 4'd4,
    REG_RD_DATA = 4'd5,
    TX_CMD      = 4'd6,
    TX_DATA     = 4'd7,
    TX_STP      = 4'd8
  } state_e;

  // Command byte prefixes: transmit command, register write and register read.
  localparam logic [3:0] TX_CMD_PREFIX = 4'h4;
  localparam logic [1:0] REG_WR_PREFIX = 2'b10;
  localparam logic [1:0] REG_RD_PREFIX = 2'b11;
  // Byte sent with stp to tell the PHY that a packet was aborted.
  localparam logic [7:0] TX_ABORT_BYTE = 8'hFF;

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [7:0] data_out_q, data_out_d;
  logic       stp_q, stp_d;
  logic       last_q, last_d;
  logic       reg_ack_q, reg_ack_d;
  logic [7:0] reg_rdata_q, reg_rdata_d;
  logic       tx_err_q, tx_err_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_cmd_valid_q, rx_cmd_valid_d;
  logic [7:0] rx_cmd_q, rx_cmd_d;

  logic       drive_en_s;
  logic       byte_valid_s;
  logic       tx_ready_s;

  // The link may drive the bus only when dir has been low for this cycle and
  // the previous one. This keeps the link off the bus in both turnaround cycles.
  assign drive_en_s   = ~ulpi_dir & ~dir_q;
  // A PHY byte is real only after the turnaround, when dir is high in both cycles.
  assign byte_valid_s = ulpi_dir & dir_q;

  assign ulpi_data    = drive_en_s ? data_out_q : 8'bzzzz_zzzz;

  assign ulpi_stp     = stp_q;
  assign reg_ack      = reg_ack_q;
  assign reg_rdata    = reg_rdata_q;
  assign tx_ready     = tx_ready_s;
  assign tx_err       = tx_err_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_cmd_valid = rx_cmd_valid_q;
  assign rx_cmd       = rx_cmd_q;

  // Delay dir by one cycle so the turnaround cycles can be detected.
  always_comb begin
    dir_d = ulpi_dir;
  end

  // Split PHY bytes into USB receive data (nxt high) and RX CMD bytes (nxt low).
  // The byte returned by a register read belongs to the read and is not a receive byte.
  always_comb begin
    rx_valid_d     = 1'b0;
    rx_cmd_valid_d = 1'b0;
    rx_data_d      = rx_data_q;
    rx_cmd_d       = rx_cmd_q;
    if (byte_valid_s && (state_q != REG_RD_DATA)) begin
      if (ulpi_nxt) begin
        rx_valid_d = 1'b1;
        rx_data_d  = ulpi_data;
      end else begin
        rx_cmd_valid_d = 1'b1;
        rx_cmd_d       = ulpi_data;
      end
    end else begin
      rx_valid_d     = 1'b0;
      rx_cmd_valid_d = 1'b0;
    end
  end

  // Bus sequencing FSM: next state, byte to drive, stp, and the handshakes
  // for register accesses and transmit packets.
  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    stp_d       = 1'b0;
    last_d      = last_q;
    reg_ack_d   = 1'b0;
    reg_rdata_d = reg_rdata_q;
    tx_err_d    = 1'b0;
    tx_ready_s  = 1'b0;

    case (state_q)
      IDLE: begin
        // reg_req is still high in the cycle that shows reg_ack. Ignore it in
        // that cycle so a finished access does not start again.
        if (drive_en_s) begin
          if (reg_req && !reg_ack_q) begin
            data_out_d = {(reg_we ? REG_WR_PREFIX : REG_RD_PREFIX), reg_addr};
            state_d    = REG_CMD;
          end else if (tx_valid) begin
            tx_ready_s = 1'b1;
            data_out_d = {TX_CMD_PREFIX, tx_data[3:0]};
            last_d     = tx_last;
            state_d    = TX_CMD;
          end else begin
            data_out_d = 8'h00;
          end
        end else begin
          data_out_d = 8'h00;
        end
      end

      REG_CMD: begin
        if (ulpi_dir) begin
          // The PHY took the bus back. Drop the access; it starts again from IDLE.
          data_out_d = 8'h00;
          state_d    = IDLE;
        end else if (ulpi_nxt) begin
          if (reg_we) begin
            data_out_d = reg_wdata;
            state_d    = REG_WDATA;
          end else begin
            data_out_d = 8'h00;
            state_d    = REG_RD_TURN;
          end
        end else begin
          state_d = REG_CMD;
        end
      end

      REG_WDATA: begin
        if (ulpi_dir) begin
          data_out_d = 8'h00;
          state_d    = IDLE;
        end else if (ulpi_nxt) begin
          stp_d      = 1'b1;
          data_out_d = 8'h00;
          state_d    = REG_STP;
        end else begin
          state_d = REG_WDATA;
        end
      end

      REG_STP: begin
        data_out_d = 8'h00;
        reg_ack_d  = 1'b1;
        state_d    = IDLE;
      end

      REG_RD_TURN: begin
        data_out_d = 8'h00;
        if (ulpi_dir) begin
          // nxt high in the turnaround means received USB data takes the bus
          // first. Return to IDLE and run the read again later.
          if (ulpi_nxt) begin
            state_d = IDLE;
          end else begin
            state_d = REG_RD_DATA;
          end
        end else begin
          state_d = REG_RD_TURN;
        end
      end

      REG_RD_DATA: begin
        data_out_d  = 8'h00;
        reg_rdata_d = ulpi_data;
        reg_ack_d   = 1'b1;
        state_d     = IDLE;
      end

      TX_CMD, TX_DATA: begin
        if (ulpi_dir) begin
          // Packet aborted by the PHY. Upstream has to flush up to tx_last.
          data_out_d = 8'h00;
          tx_err_d   = 1'b1;
          state_d    = IDLE;
        end else if (ulpi_nxt) begin
          if (last_q) begin
            stp_d      = 1'b1;
            data_out_d = 8'h00;
            state_d    = TX_STP;
          end else if (tx_valid) begin
            tx_ready_s = 1'b1;
            data_out_d = tx_data;
            last_d     = tx_last;
            state_d    = TX_DATA;
          end else begin
            // Underrun: stop the packet with the abort byte.
            stp_d      = 1'b1;
            data_out_d = TX_ABORT_BYTE;
            tx_err_d   = 1'b1;
            state_d    = TX_STP;
          end
        end else begin
          state_d = state_q;
        end
      end

      TX_STP: begin
        data_out_d = 8'h00;
        state_d    = IDLE;
      end

      default: begin
        data_out_d = 8'h00;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers. Reset puts every flop back to its idle value at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      dir_q          <= 1'b0;
      data_out_q     <= 8'h00;
      stp_q          <= 1'b0;
      last_q         <= 1'b0;
      reg_ack_q      <= 1'b0;
      reg_rdata_q    <= 8'h00;
      tx_err_q       <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= 8'h00;
      rx_cmd_valid_q <= 1'b0;
      rx_cmd_q       <= 8'h00;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      data_out_q     <= data_out_d;
      stp_q          <= stp_d;
      last_q         <= last_d;
      reg_ack_q      <= reg_ack_d;
      reg_rdata_q    <= reg_rdata_d;
      tx_err_q       <= tx_err_d;
      rx_valid_q     <= rx_valid_d;
      rx_data_q      <= rx_data_d;
      rx_cmd_valid_q <= rx_cmd_valid_d;
      rx_cmd_q       <= rx_cmd_d;
    end
  end

endmodule

// File: tb/tb_ulpi_link.sv
// tb_ulpi_link: randomized bench for ulpi_link.
// A transaction-level PHY/host model drives the inputs. Bus bytes,
// handshakes and receive strobes are compared against values worked out
// from each transaction's contents.
module tb_ulpi_link;

  logic       clk;
  logic       rst_n;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  wire  [7:0] ulpi_data;
  logic       reg_req;
  logic       reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic [7:0] reg_rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_err;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_cmd_valid;
  logic [7:0] rx_cmd;

  logic [7:0] phy_data;
  logic [7:0] exp_cmd;
  logic [7:0] tx_pkt[$];
  int         n_checks;
  int         n_errors;

  // The PHY model drives the bus whenever dir is high, including the rising turnaround.
  assign ulpi_data = ulpi_dir ? phy_data : 8'hzz;

  ulpi_link dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ulpi_dir     (ulpi_dir),
    .ulpi_nxt     (ulpi_nxt),
    .ulpi_stp     (ulpi_stp),
    .ulpi_data    (ulpi_data),
    .reg_req      (reg_req),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_ack      (reg_ack),
    .reg_rdata    (reg_rdata),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .tx_err       (tx_err),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_cmd_valid (rx_cmd_valid),
    .rx_cmd       (rx_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Link-driven byte: random stall, then the PHY accepts it with nxt.
  task automatic link_byte(input string tag, input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      ulpi_nxt = 1'b0;
      #1 check(tag, ulpi_data, b);
      step();
    end
    ulpi_nxt = 1'b1;
    #1 check(tag, ulpi_data, b);
    step();
    ulpi_nxt = 1'b0;
  endtask

  task automatic rx_begin();
    ulpi_dir = 1'b1;
    ulpi_nxt = 1'b0;
    phy_data = 8'($urandom);
    #1 check("rx_ta_bus", ulpi_data, phy_data);
    step();
    check("rx_ta_valid", rx_valid, 1'b0);
    check("rx_ta_cmdv", rx_cmd_valid, 1'b0);
  endtask

  task automatic rx_byte(input logic n, input logic [7:0] b);
    phy_data = b;
    ulpi_nxt = n;
    step();
    check("rx_valid", rx_valid, n);
    check("rx_cmd_valid", rx_cmd_valid, !n);
    if (n) check("rx_data", rx_data, b);
    else exp_cmd = b;
    check("rx_cmd", rx_cmd, exp_cmd);
  endtask

  task automatic rx_end();
    ulpi_dir = 1'b0;
    ulpi_nxt = 1'b0;
    step();
    check("rx_end_valid", rx_valid, 1'b0);
    check("rx_end_cmdv", rx_cmd_valid, 1'b0);
  endtask

  // mode 0: plain write, 1: PHY takes the bus during the command byte, 2: reset while stp is high
  task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input int mode, input bit with_tx);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    if (with_tx) begin
      tx_valid = 1'b1; tx_data = 8'($urandom); tx_last = 1'b1;
    end
    #1 check("prio_rdy", tx_ready, 1'b0);
    step();
    tx_valid = 1'b0; tx_last = 1'b0;
    if (mode == 1) begin
      check("wabort_pre", ulpi_data, 8'h80 + a);
      ulpi_dir = 1'b1;
      phy_data = 8'($urandom);
      #1 check("wabort_ta", ulpi_data, phy_data);
      step();
      check("wabort_ack", reg_ack, 1'b0);
      check("wabort_stp", ulpi_stp, 1'b0);
      ulpi_dir = 1'b0;
      step();
      step();
    end
    link_byte("wcmd", 8'h80 + a);
    link_byte("wdata", d);
    check("w_stp", ulpi_stp, 1'b1);
    check("w_stp_bus", ulpi_data, 8'h00);
    check("w_ack_early", reg_ack, 1'b0);
    if (mode == 2) begin
      rst_n = 1'b0;
      #1 check("rst_stp", ulpi_stp, 1'b0);
      check("rst_bus", ulpi_data, 8'h00);
      check("rst_rxcmd", rx_cmd, 8'h00);
      reg_req = 1'b0;
      exp_cmd = 8'h00;
      step();
      step();
      rst_n = 1'b1;
      step();
      check("rst_ack", reg_ack, 1'b0);
      return;
    end
    step();
    check("w_ack", reg_ack, 1'b1);
    check("w_ack_stp", ulpi_stp, 1'b0);
    reg_req = 1'b0;
    step();
    check("w_ack_pulse", reg_ack, 1'b0);
  endtask

  task automatic reg_read(input logic [5:0] a, input logic [7:0] v, input bit preempt);
    int tries;
    tries = preempt ? 2 : 1;
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
    for (int t = 0; t < tries; t++) begin
      step();
      link_byte("rcmd", 8'hC0 + a);
      repeat ($urandom_range(0, 2)) begin
        #1 check("rturn_bus", ulpi_data, 8'h00);
        step();
      end
      ulpi_dir = 1'b1;
      ulpi_nxt = (t == 0) && preempt;
      phy_data = 8'($urandom);
      #1 check("rta_bus", ulpi_data, phy_data);
      step();
      if ((t == 0) && preempt) begin
        check("rpre_ack", reg_ack, 1'b0);
        rx_byte(1'b1, 8'($urandom));
        rx_byte(1'b1, 8'($urandom));
        rx_end();
      end
    end
    phy_data = v;
    ulpi_nxt = 1'b0;
    step();
    check("r_ack", reg_ack, 1'b1);
    check("r_rdata", reg_rdata, v);
    check("r_no_rxv", rx_valid, 1'b0);
    check("r_no_rxcmdv", rx_cmd_valid, 1'b0);
    check("r_rxcmd_hold", rx_cmd, exp_cmd);
    reg_req = 1'b0;
    rx_end();
    check("r_ack_pulse", reg_ack, 1'b0);
  endtask

  // Sends tx_pkt. mode 0: complete, 1: upstream stops after byte 'cut',
  // 2: PHY raises dir while byte 'cut' is on the bus
  task automatic tx_packet(input int mode, input int cut);
    int n;
    int avail;
    int cnt;
    logic [7:0] exp;
    n = tx_pkt.size();
    avail = (mode == 1) ? cut + 1 : n;
    cnt = 0;
    tx_valid = 1'b1; tx_data = tx_pkt[0]; tx_last = (n == 1);
    #1 check("tx_rdy0", tx_ready, 1'b1);
    if (tx_ready) cnt++;
    step();
    for (int i = 0; i < n; i++) begin
      exp = (i == 0) ? 8'(8'h40 + (tx_pkt[0] % 16)) : tx_pkt[i];
      if (i + 1 < avail) begin
        tx_valid = 1'b1; tx_data = tx_pkt[i+1]; tx_last = (i + 1 == n - 1);
      end else begin
        tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        ulpi_nxt = 1'b0;
        #1 check("tx_hold", ulpi_data, exp);
        check("tx_rdy_stall", tx_ready, 1'b0);
        step();
      end
      if ((mode == 2) && (i == cut)) begin
        ulpi_dir = 1'b1;
        phy_data = 8'($urandom);
        #1 check("tx_ta_bus", ulpi_data, phy_data);
        check("tx_ta_rdy", tx_ready, 1'b0);
        step();
        check("tx_abort_err", tx_err, 1'b1);
        check("tx_abort_stp", ulpi_stp, 1'b0);
        check("tx_abort_cnt", cnt, i + 1);
        tx_valid = 1'b0; tx_last = 1'b0;
        ulpi_dir = 1'b0;
        step();
        check("tx_abort_pulse", tx_err, 1'b0);
        return;
      end
      ulpi_nxt = 1'b1;
      #1 check("tx_bus", ulpi_data, exp);
      check("tx_rdy", tx_ready, (i + 1 < avail));
      if (tx_valid && tx_ready) cnt++;
      step();
      ulpi_nxt = 1'b0;
      if (i + 1 >= avail) break;
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    check("tx_stp", ulpi_stp, 1'b1);
    check("tx_end_bus", ulpi_data, (mode == 1) ? 8'hFF : 8'h00);
    check("tx_err", tx_err, (mode == 1));
    check("tx_cnt", cnt, avail);
    step();
    check("tx_stp_end", ulpi_stp, 1'b0);
    check("tx_err_end", tx_err, 1'b0);
    check("tx_idle_bus", ulpi_data, 8'h00);
  endtask

  task automatic rand_pkt(input int n);
    tx_pkt.delete();
    for (int i = 0; i < n; i++) tx_pkt.push_back(8'($urandom));
  endtask

  // Watchdog so the run ends even if something stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus: directed scenarios first, then random transactions.
  initial begin
    int n;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = 6'h00; reg_wdata = 8'h00;
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    phy_data = 8'h00; exp_cmd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stp0", ulpi_stp, 1'b0);
    check("rst_bus0", ulpi_data, 8'h00);
    check("rst_ack0", reg_ack, 1'b0);
    check("rst_rdata0", reg_rdata, 8'h00);
    check("rst_txerr0", tx_err, 1'b0);
    check("rst_rxv0", rx_valid, 1'b0);
    check("rst_rxd0", rx_data, 8'h00);
    check("rst_rxcv0", rx_cmd_valid, 1'b0);
    check("rst_rxc0", rx_cmd, 8'h00);
    check("rst_rdy0", tx_ready, 1'b0);
    rst_n = 1'b1;
    step();

    reg_write(6'h0A, 8'h55, 0, 1'b0);
    reg_read(6'h01, 8'h24, 1'b0);
    rx_begin();
    rx_byte(1'b0, 8'h4C);
    rx_byte(1'b1, 8'hC3);
    rx_byte(1'b1, 8'h01);
    rx_end();
    tx_pkt = '{8'h03, 8'hAA, 8'hBB};
    tx_packet(0, 0);
    rand_pkt(3);
    tx_packet(1, 0);
    reg_write(6'h15, 8'hA7, 0, 1'b1);
    reg_write(6'h2E, 8'h3C, 1, 1'b0);
    reg_read(6'h07, 8'h9D, 1'b1);
    rand_pkt(4);
    tx_packet(2, 1);
    reg_write(6'h33, 8'hE1, 2, 1'b0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0: reg_write(6'($urandom), 8'($urandom), 0, 1'($urandom_range(0, 1)));
        1: reg_write(6'($urandom), 8'($urandom), 1, 1'b0);
        2: reg_read(6'($urandom), 8'($urandom), 1'b0);
        3: reg_read(6'($urandom), 8'($urandom), 1'b1);
        4: begin
          rx_begin();
          repeat ($urandom_range(1, 5)) rx_byte(1'($urandom_range(0, 1)), 8'($urandom));
          rx_end();
        end
        5: begin
          rand_pkt($urandom_range(1, 6));
          tx_packet(0, 0);
        end
        6: begin
          n = $urandom_range(2, 5);
          rand_pkt(n);
          tx_packet(1, $urandom_range(0, n - 2));
        end
        default: begin
          n = $urandom_range(1, 5);
          rand_pkt(n);
          tx_packet(2, $urandom_range(0, n - 1));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ulpi_link.md
Name: ulpi_link

Overview:
- Link-side ULPI controller. Sits between the USB link logic and an external ULPI PHY.
- Owns the link half of the ULPI bus: dir/nxt in, stp out, 8-bit bidirectional data.
- Serializes register writes/reads and USB transmit packets onto the bus.
- Demultiplexes PHY-driven bytes into RX CMD and USB RX data streams.

Parameters:
- none

Ports:
- clk  in  1  ULPI 60 MHz clock; everything on posedge.
- rst_n  in  1  Asynchronous active-low reset.
- ulpi_dir  in  1  PHY owns data bus when high.
- ulpi_nxt  in  1  PHY throttle / data-valid strobe.
- ulpi_stp  out  1  Link stop strobe.
- ulpi_data  inout  8  Bus. Link drives only when drive_en=1, else high-Z.
- reg_req  in  1  Register access request. Held until reg_ack.
- reg_we  in  1  1=write, 0=read.
- reg_addr  in  6  PHY register address.
- reg_wdata  in  8  Write data.
- reg_ack  out  1  One-cycle completion pulse.
- reg_rdata  out  8  Read result. Valid with reg_ack on reads.
- tx_valid  in  1  TX byte stream valid. First byte of a packet carries PID in [3:0].
- tx_data  in  8  TX byte.
- tx_last  in  1  Marks final byte of packet.
- tx_ready  out  1  Combinational accept; byte consumed when tx_valid & tx_ready.
- tx_err  out  1  One-cycle pulse on aborted/underrun packet.
- rx_valid  out  1  USB RX data byte strobe.
- rx_data  out  8  USB RX byte.
- rx_cmd_valid  out  1  RX CMD strobe.
- rx_cmd  out  8  Last RX CMD byte; holds until next RX CMD.

Behaviour:
- Reset: stp=0, data_out=0, reg_ack=0, reg_rdata=0, tx_err=0, rx_valid=0, rx_cmd_valid=0, rx_data=0, rx_cmd=0, state IDLE.
- dir_q = ulpi_dir registered.
- drive_en = !ulpi_dir & !dir_q. No driving in either turnaround cycle.
- PHY byte valid only when ulpi_dir & dir_q.
- RX path (outside REG_RD_DATA): on PHY byte valid, next cycle:
  - nxt=1 → rx_valid=1, rx_data=byte.
  - nxt=0 → rx_cmd_valid=1, rx_cmd=byte.
  - Strobes are single-cycle.
- States: IDLE, REG_CMD, REG_WDATA, REG_STP, REG_RD_TURN, REG_RD_DATA, TX_CMD, TX_DATA, TX_STP.
- IDLE, bus free (drive_en=1):
  - reg_req has priority → data_out={reg_we?2'b10:2'b11, reg_addr}, go REG_CMD.
  - else tx_valid → tx_ready=1, data_out={4'h4, tx_data[3:0]}, last_q=tx_last, go TX_CMD.
  - Otherwise data_out=0.
- REG_CMD, nxt=1 & dir=0:
  - write → data_out=reg_wdata, go REG_WDATA.
  - read → data_out=0, go REG_RD_TURN.
- REG_WDATA, nxt=1 → stp=1, data_out=0, go REG_STP.
- REG_STP → stp=0, reg_ack=1 next cycle, go IDLE.
- REG_RD_TURN: wait for dir=1.
  - Turnaround cycle with nxt=0 → go REG_RD_DATA.
  - Turnaround cycle with nxt=1 (PHY RX preempts) → go IDLE; request stays pending; retry.
- REG_RD_DATA: capture ulpi_data → reg_rdata, reg_ack=1, go IDLE.
- dir rising in REG_CMD or REG_WDATA → go IDLE, data_out=0, no ack; access retried once bus is free.
- TX_CMD/TX_DATA, nxt=1:
  - last_q=1 → stp=1, data_out=0, go TX_STP.
  - else if tx_valid → tx_ready=1, data_out=tx_data, last_q=tx_last, state TX_DATA.
  - else underrun → stp=1, data_out=8'hFF, tx_err=1, go TX_STP.
- TX_STP → stp=0, data_out=0, go IDLE.
- dir rising during TX_CMD/TX_DATA → go IDLE, stp=0, tx_err=1. Remaining bytes are not consumed; upstream must flush to tx_last.
- Reset mid-operation returns everything to reset values immediately.

Test Plan:
- Register write addr=6'h0A data=8'h55, PHY nxt one cycle after each byte → bus shows 8'h8A, 8'h55, then stp=1 with data 8'h00; reg_ack pulses one cycle after stp.
- Register read addr=6'h01 → 8'hC1 driven; on nxt, PHY raises dir, turnaround, then drives 8'h24 → reg_rdata=8'h24, reg_ack=1; link drove nothing while dir or dir_q was high.
- PHY RX: dir high, turnaround, nxt=0 byte 8'h4C, then nxt=1 bytes 8'hC3, 8'h01 → rx_cmd=8'h4C with one rx_cmd_valid, then rx_valid twice with rx_data 8'hC3, 8'h01.
- TX packet PID 4'h3 plus bytes 8'hAA, 8'hBB (tx_last on 8'hBB), nxt each cycle → 8'h43, 8'hAA, 8'hBB, then stp with 8'h00; tx_ready fires 3 times.
- TX underrun: tx_valid drops after PID byte → stp=1, data=8'hFF, tx_err pulse.
- Simultaneous reg_req and tx_valid → register access first. dir rising during REG_CMD → abort, then retry after dir falls. rst_n low mid-write → stp=0, state IDLE.
